// File: rtl/axi_rd_responder_pkg.sv
// axi_rd_responder_pkg: shared types and constants for the AXI-lite read responder
package axi_rd_responder_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/axi_rd_latency_ctr.sv
// axi_rd_latency_ctr: loadable 4-bit down-counter modelling memory latency
module axi_rd_latency_ctr #(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= 4'(LATENCY);
    else if (en && cnt != '0) cnt <= cnt - 4'd1;
  end
  assign done = (cnt == 4'd1) || (LATENCY == 0);
endmodule

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: single-outstanding AXI-lite read responder over a synchronous 64-bit memory
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0800_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_araddr,
  input  logic              io_arvalid,
  output logic              io_arready,
  output logic              io_rvalid,
  input  logic              io_rready,
  output logic [DATA_W-1:0] io_rdata,
  output logic [1:0]        io_rresp,
  output logic              io_mem_en,
  output logic [ADDR_W-1:0] io_mem_addr,
  input  logic [DATA_W-1:0] io_mem_rdata
);
  state_t state, state_nx;
  logic [ADDR_W-1:3] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0] resp_q;
  logic cap_q, live_q, ar_hs, r_hs, in_range, done;
  assign io_arready = live_q && state == IDLE;
  assign io_rvalid = state == RESP;
  assign ar_hs = io_arvalid && io_arready;
  assign r_hs = io_rvalid && io_rready;
  assign in_range = (io_araddr >= BASE_ADDR) && (io_araddr - BASE_ADDR < MEM_BYTES);
  assign io_mem_en = state == ISSUE;
  assign io_mem_addr = {addr_q, 3'b000};
  // memory data lands the cycle after ISSUE; forward it live so LATENCY==0 responds without a bubble
  assign io_rdata = cap_q ? io_mem_rdata : rdata_q;
  assign io_rresp = resp_q;
  axi_rd_latency_ctr #(.LATENCY(LATENCY)) u_ctr (
    .clk (clock),
    .rst (reset),
    .load(state == ISSUE),
    .en  (state == WAIT),
    .done(done)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ar_hs ? (in_range ? ISSUE : RESP) : IDLE;
      ISSUE:   state_nx = done ? RESP : WAIT;
      WAIT:    state_nx = done ? RESP : WAIT;
      default: state_nx = r_hs ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      cap_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      live_q <= 1'b1;
      cap_q  <= state == ISSUE;
      if (cap_q) rdata_q <= io_mem_rdata;
      if (ar_hs) begin
        addr_q <= io_araddr[ADDR_W-1:3];
        resp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
        if (!in_range) rdata_q <= '0;
      end
    end
  end
endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI-lite read-channel responder (slave end) serving the instruction-fetch initiator's AR/R channels from a synchronous 64-bit memory port.
- Accepts one read address at a time and waits a programmable number of cycles to model memory latency.
- Returns 64-bit data with a response code and holds it until the initiator accepts.
- Sits between the fetch-side AXI initiator and the simulation/backing memory.

Parameters:
- LATENCY, 2, extra wait cycles between memory read issue and rvalid (0..15)
- BASE_ADDR, 32'h8000_0000, lowest legal byte address
- MEM_BYTES, 32'h0800_0000, size of legal window in bytes

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- io_araddr  input  32  read byte address
- io_arvalid  input  1  address valid
- io_arready  output  1  address accepted when high with arvalid
- io_rvalid  output  1  read data valid
- io_rready  input  1  initiator ready for data
- io_rdata  output  64  read data
- io_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR
- io_mem_en  output  1  memory read strobe (one cycle)
- io_mem_addr  output  32  8-byte-aligned memory address
- io_mem_rdata  input  64  memory data, valid the cycle after io_mem_en

Behaviour:
- Interface: one clock (clock); reset is synchronous, active-high (reset).
- Reset values: io_arready=0, io_rvalid=0, io_rdata=0, io_rresp=0, io_mem_en=0, io_mem_addr=0; state=IDLE, counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - io_arready=1; a handshake occurs on arvalid&&arready.
  - On handshake: latch araddr and compute in_range = (araddr >= BASE_ADDR) && (araddr - BASE_ADDR < MEM_BYTES), using 32-bit unsigned subtraction with no wrap past 2^32.
  - If in_range, go to ISSUE; otherwise set rresp=SLVERR, rdata=0, and go to RESP.
- ISSUE:
  - io_mem_en=1 for exactly one cycle; io_mem_addr = {latched[31:3], 3'b000}; arready=0.
  - Next cycle: capture io_mem_rdata into the rdata register.
  - If LATENCY==0, go to RESP with rresp=OKAY; else load counter=LATENCY and go to WAIT.
- WAIT: decrement counter each cycle; when counter reaches 1, go to RESP with rresp=OKAY.
- RESP:
  - rvalid=1; rdata and rresp are stable while rvalid && !rready (AXI rule).
  - On rvalid&&rready: go to IDLE; rvalid=0 next cycle.
- Latency:
  - Address handshake at cycle T; mem_en at T+1.
  - OKAY rvalid first asserted at T+2+LATENCY. Example: LATENCY=2 gives rvalid at T+4.
  - SLVERR rvalid first asserted at T+1; no mem_en pulse.
- Single outstanding transaction:
  - arready is low from the handshake until the cycle after the R handshake.
  - Back-to-back throughput is one transaction per 3+LATENCY cycles with rready held high.
- Unaligned araddr is not an error: the low 3 bits are ignored for the memory address; the initiator selects the word.
- arvalid dropped before the handshake: no effect. The responder never requires arvalid to stay high.
- rready held low indefinitely: stay in RESP; no new address is accepted.
- Reset mid-transaction (any state): next cycle returns to IDLE with all outputs at reset values. The pending response is discarded and mem_en is not re-issued.
- Address at the boundary: BASE_ADDR+MEM_BYTES-1 returns OKAY; BASE_ADDR+MEM_BYTES returns SLVERR; BASE_ADDR-1 returns SLVERR.

Decomposition:
- Shared package holds:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - AXI data width 64 and address width 32
- One sub-module, axi_rd_latency_ctr: loadable 4-bit down-counter with load, enable, and a done (==1 or LATENCY==0) output.
- The FSM, address-range check, and data/resp registers stay in the top module.

Test Plan:
- Basic OKAY read, LATENCY=2, rready=1:
  - araddr=0x8000_0010, mem returns 0x1122334455667788.
  - Expect: mem_en one cycle at T+1 with mem_addr=0x8000_0010; rvalid at T+4; rdata=0x1122334455667788; rresp=00; arready back high at T+5.
- Out-of-range read:
  - araddr=0x7FFF_FFFC: expect rvalid at T+1, rresp=10, rdata=0, no mem_en.
  - Repeat with araddr=0x8800_0000: same SLVERR response.
- Backpressure:
  - rready=0 for 5 cycles after rvalid: rvalid, rdata, and rresp stay constant; arready stays 0 with arvalid held high.
  - Then rready=1: single handshake.
- Unaligned and back-to-back:
  - araddr=0x8000_0004 gives mem_addr=0x8000_0000.
  - Continuous arvalid with addresses 0x8000_0000, 0x8000_0008, 0x8000_0010 and LATENCY=0: exactly 3 responses in order, spaced 3 cycles apart.
- Reset mid-WAIT:
  - Assert reset for 1 cycle while in WAIT: next cycle rvalid=0, arready=0.
  - Following cycle arready=1; no stale response ever appears.
- Boundary addresses:
  - 0x87FF_FFF8 returns OKAY with mem_addr=0x87FF_FFF8.
  - 0x8800_0000 returns SLVERR.
